// File: rtl/uart_apb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_apb_pkg
// Brief    : Register map, bit indices and FSM encoding shared by UART APB front ends.
// Revision : 1.0
// ============================================================================
package uart_apb_pkg;

  // Register offsets as seen on paddr[3:2]
  localparam logic [1:0] c_addr_rxdata = 2'd0;
  localparam logic [1:0] c_addr_status = 2'd1;
  localparam logic [1:0] c_addr_irq_en = 2'd2;
  localparam logic [1:0] c_addr_rsvd   = 2'd3;

  localparam int unsigned c_stat_empty = 0;
  localparam int unsigned c_stat_full  = 1;
  localparam int unsigned c_stat_fe    = 2;
  localparam int unsigned c_stat_ovr   = 3;

  localparam int unsigned c_irqen_ne   = 0;
  localparam int unsigned c_irqen_err  = 1;

  // rx_stat = {full, empty, overrun pulse, frame-error pulse}
  localparam int unsigned c_rx_fe      = 0;
  localparam int unsigned c_rx_ovr     = 1;
  localparam int unsigned c_rx_empty   = 2;
  localparam int unsigned c_rx_full    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_stat_sticky.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_stat_sticky
// Brief    : Sticky frame/overrun flags (set beats W1C) and registered irq combine.
// Revision : 1.0
// ============================================================================
module uart_stat_sticky
  import uart_apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_fe_set,
  input  logic       i_ovr_set,
  input  logic       i_fe_clr,
  input  logic       i_ovr_clr,
  input  logic       i_empty,
  input  logic [1:0] i_irq_en,
  output logic       o_fe,
  output logic       o_ovr,
  output logic       o_irq
);

  logic r_fe;
  logic r_ovr;
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fe  <= 1'b0;
      r_ovr <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (i_fe_set)       r_fe <= 1'b1;
      else if (i_fe_clr)  r_fe <= 1'b0;

      if (i_ovr_set)      r_ovr <= 1'b1;
      else if (i_ovr_clr) r_ovr <= 1'b0;

      r_irq <= (i_irq_en[c_irqen_ne]  & ~i_empty) |
               (i_irq_en[c_irqen_err] & (r_fe | r_ovr));
    end
  end

  assign o_fe  = r_fe;
  assign o_ovr = r_ovr;
  assign o_irq = r_irq;

endmodule
`default_nettype wire

// File: rtl/apb_uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_uart_rx_if
// Brief    : APB3 slave for the UART RX FIFO: data pops, live/sticky status, irq.
// Revision : 1.0
// ============================================================================
module apb_uart_rx_if
  import uart_apb_pkg::*;
#(
  parameter int APB_DW = 32,
  parameter int RX_DW  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [3:0]        paddr_i,
  input  logic [APB_DW-1:0] pwdata_i,
  output logic [APB_DW-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              rden_o,
  input  logic [RX_DW-1:0]  rd_data_i,
  input  logic [3:0]        rx_stat_i,
  output logic              irq_o
);

  rx_state_e         r_state;
  logic [RX_DW-1:0]  r_rx_byte;
  logic [1:0]        r_irq_en;

  logic [1:0]        w_addr;
  logic              w_empty;
  logic              w_full;
  logic              w_setup;
  logic              w_idle_acc;
  logic              w_wr;
  logic              w_rd;
  logic              w_pop_req;
  logic              w_err;
  logic              w_fe;
  logic              w_ovr;
  logic [APB_DW-1:0] w_reg_rdata;
  logic              w_unused;

  assign w_addr     = paddr_i[3:2];
  assign w_empty    = rx_stat_i[c_rx_empty];
  assign w_full     = rx_stat_i[c_rx_full];
  assign w_setup    = psel_i & ~penable_i;
  assign w_idle_acc = (r_state == ST_IDLE) & psel_i & penable_i;
  assign w_wr       = w_idle_acc & pwrite_i;
  assign w_rd       = w_idle_acc & ~pwrite_i;

  // Empty is judged in the setup cycle; a pop is committed only from there.
  assign w_pop_req  = (r_state == ST_IDLE) & w_setup & ~pwrite_i &
                      (w_addr == c_addr_rxdata) & ~w_empty;
  // Any RXDATA access still in IDLE at its access phase is a write or an empty read.
  assign w_err      = w_idle_acc & ((w_addr == c_addr_rxdata) | (w_addr == c_addr_rsvd));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_rx_byte <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pop_req) r_state <= ST_POP;
        ST_POP:  r_state <= psel_i ? ST_CAPT : ST_IDLE;
        ST_CAPT: begin
          if (psel_i) begin
            r_rx_byte <= rd_data_i;
            r_state   <= ST_RESP;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_en <= '0;
    end else if (w_wr && (w_addr == c_addr_irq_en)) begin
      r_irq_en <= pwdata_i[1:0];
    end
  end

  uart_stat_sticky u_sticky (
    .clk       (clk_i),
    .rst       (rst_i),
    .i_fe_set  (rx_stat_i[c_rx_fe]),
    .i_ovr_set (rx_stat_i[c_rx_ovr]),
    .i_fe_clr  (w_wr & (w_addr == c_addr_status) & pwdata_i[c_stat_fe]),
    .i_ovr_clr (w_wr & (w_addr == c_addr_status) & pwdata_i[c_stat_ovr]),
    .i_empty   (w_empty),
    .i_irq_en  (r_irq_en),
    .o_fe      (w_fe),
    .o_ovr     (w_ovr),
    .o_irq     (irq_o)
  );

  always_comb begin
    w_reg_rdata = '0;
    case (w_addr)
      c_addr_status: begin
        w_reg_rdata[c_stat_empty] = w_empty;
        w_reg_rdata[c_stat_full]  = w_full;
        w_reg_rdata[c_stat_fe]    = w_fe;
        w_reg_rdata[c_stat_ovr]   = w_ovr;
      end
      c_addr_irq_en: w_reg_rdata[1:0] = r_irq_en;
      default:       w_reg_rdata = '0;
    endcase
  end

  // The captured byte is held on the bus between zero-wait register reads.
  assign prdata_o  = w_rd ? w_reg_rdata : {{(APB_DW-RX_DW){1'b0}}, r_rx_byte};
  assign pready_o  = w_idle_acc | (r_state == ST_RESP);
  assign pslverr_o = w_err;
  assign rden_o    = (r_state == ST_POP);

  assign w_unused  = ^{paddr_i[1:0], pwdata_i[APB_DW-1:4]};

endmodule
`default_nettype wire
